// File: rtl/apb_pkg.sv
// Shared types and default sizing for the round-robin APB master.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned APB_NUM_REQ = 2;
    localparam int unsigned APB_ADDR_W  = 4;
    localparam int unsigned APB_DATA_W  = 32;
    localparam int unsigned APB_TIMEOUT = 16;

endpackage

// File: rtl/apb_rr_master_if.sv
// Requester command/response bundle plus the APB bus, with master and slave views.
interface apb_rr_master_if
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REQ = APB_NUM_REQ,
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_gnt;
    logic [NUM_REQ-1:0]        req_done;
    logic [DATA_W-1:0]         req_rdata;
    logic                      req_err;

    logic [ADDR_W-1:0]         PADDR;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [DATA_W-1:0]         PWDATA;
    logic [DATA_W-1:0]         PRDATA;
    logic                      PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        output req_gnt, req_done, req_rdata, req_err,
               PADDR, PWRITE, PSEL, PENABLE, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        input  req_gnt, req_done, req_rdata, req_err,
               PADDR, PWRITE, PSEL, PENABLE, PWDATA
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: the requester served last gets the lower priority.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic [0:0] last,
    output logic [1:0] gnt,
    output logic       any
);

    always_comb begin
        gnt = 2'b00;
        if (last[0]) begin
            gnt[0] = req[0];
            gnt[1] = req[1] & ~req[0];
        end else begin
            gnt[1] = req[1];
            gnt[0] = req[0] & ~req[1];
        end
    end

    assign any = |req;

endmodule

// File: rtl/apb_rr_master.sv
// Shares one APB bus between two requesters: round-robin grant, SETUP/ACCESS
// sequencing with wait states, and abort after TIMEOUT unready ACCESS cycles.
module apb_rr_master
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REQ = APB_NUM_REQ,
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = APB_TIMEOUT
) (
    input  logic            PCLK,
    input  logic            PRESET,
    apb_rr_master_if.master bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    apb_state_e         r_state, w_state_nxt;
    logic               r_owner, w_owner_nxt;
    logic               r_last, w_last_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_psel, w_psel_nxt;
    logic               r_penable, w_penable_nxt;
    logic               r_pwrite, w_pwrite_nxt;
    logic [ADDR_W-1:0]  r_paddr, w_paddr_nxt;
    logic [DATA_W-1:0]  r_pwdata, w_pwdata_nxt;
    logic [NUM_REQ-1:0] r_done, w_done_nxt;
    logic [DATA_W-1:0]  r_rdata, w_rdata_nxt;
    logic               r_err, w_err_nxt;
    logic [NUM_REQ-1:0] w_gnt;
    logic [1:0]         w_arb_gnt;
    logic               w_arb_any;
    logic               w_win;

    rr_arbiter_2 u_arb (
        .req  (bus.req_valid),
        .last (r_last),
        .gnt  (w_arb_gnt),
        .any  (w_arb_any)
    );

    assign w_win = w_arb_gnt[1];

    // Next-state and next-output logic; PSEL/PENABLE follow the next state so
    // they are registered yet line up with the phase they describe.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_cnt;
        w_pwrite_nxt  = r_pwrite;
        w_paddr_nxt   = r_paddr;
        w_pwdata_nxt  = r_pwdata;
        w_rdata_nxt   = r_rdata;
        w_done_nxt    = '0;
        w_err_nxt     = 1'b0;
        w_gnt         = '0;

        case (r_state)
            IDLE: begin
                if (w_arb_any) begin
                    w_gnt        = w_arb_gnt;
                    w_owner_nxt  = w_win;
                    w_last_nxt   = w_win;
                    w_pwrite_nxt = bus.req_write[w_win];
                    w_paddr_nxt  = w_win ? bus.req_addr[ADDR_W +: ADDR_W]
                                         : bus.req_addr[0 +: ADDR_W];
                    w_pwdata_nxt = w_win ? bus.req_wdata[DATA_W +: DATA_W]
                                         : bus.req_wdata[0 +: DATA_W];
                    w_state_nxt  = SETUP;
                end
            end
            SETUP: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    w_done_nxt[r_owner] = 1'b1;
                    if (!r_pwrite) begin
                        w_rdata_nxt = bus.PRDATA;
                    end
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_done_nxt[r_owner] = 1'b1;
                    w_err_nxt           = 1'b1;
                    w_rdata_nxt         = '0;
                    w_state_nxt         = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_psel_nxt    = (w_state_nxt != IDLE);
        w_penable_nxt = (w_state_nxt == ACCESS);
    end

    // Pointer resets to "req1 served last" so requester 0 wins the first tie.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state   <= IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_done    <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_pwrite  <= w_pwrite_nxt;
            r_paddr   <= w_paddr_nxt;
            r_pwdata  <= w_pwdata_nxt;
            r_done    <= w_done_nxt;
            r_rdata   <= w_rdata_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign bus.req_gnt   = w_gnt;
    assign bus.req_done  = r_done;
    assign bus.req_rdata = r_rdata;
    assign bus.req_err   = r_err;
    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_rr_master.sv
// Scoreboard bench for apb_rr_master: directed requests, a small APB slave
// with configurable wait states, and a negedge monitor checking grants/completions.
module tb_apb_rr_master;
    import apb_pkg::*;

    typedef struct packed {
        logic [1:0]  done;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    apb_rr_master_if bus ();

    apb_rr_master #(.TIMEOUT(16)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    // Slave: memory, wait-state count, never-ready and stale-ready controls
    logic [31:0] mem [16];
    int unsigned slv_wait = 0;
    logic        slv_never = 1'b0;
    logic        slv_stale = 1'b0;
    int unsigned acc;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            acc <= 0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[12] <= 32'h12345678;
        end else begin
            if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc <= acc + 1;
            else acc <= 0;
            if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE)
                mem[bus.PADDR] <= bus.PWDATA;
        end
    end

    always_comb begin
        bus.PRDATA = mem[bus.PADDR];
        if (bus.PSEL && bus.PENABLE) bus.PREADY = !slv_never && (acc >= slv_wait);
        else                         bus.PREADY = slv_stale;
    end

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    exp_t       exp_q[$];
    logic [1:0] gnt_q[$];
    int tests = 0;
    int fails = 0;
    int done_cyc = 0;
    int acc_cyc = 0;
    int t0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock: note any grant, then drop the granted requester's valid.
    task automatic step();
        logic [1:0] g;
        @(negedge PCLK);
        g = bus.req_gnt;
        @(posedge PCLK);
        #1;
        bus.req_valid = bus.req_valid & ~g;
    endtask

    task automatic set_req(input int i, input logic w, input logic [3:0] a, input logic [31:0] d);
        bus.req_valid[i]         = 1'b1;
        bus.req_write[i]         = w;
        bus.req_addr[i*4 +: 4]   = a;
        bus.req_wdata[i*32 +: 32] = d;
    endtask

    task automatic expect_xfer(input logic [1:0] g, input logic [31:0] r, input logic e);
        exp_t x;
        x.done = g; x.rdata = r; x.err = e;
        gnt_q.push_back(g);
        exp_q.push_back(x);
    endtask

    task automatic wait_done(input string name, input int max);
        for (int k = 0; k < max && exp_q.size() != 0; k++) step();
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        bus.req_valid = 2'b00;
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
    endtask

    initial begin
        PRESET        = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_write = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge PCLK);
                    if (bus.PSEL && bus.PENABLE) acc_cyc++;
                    if (bus.req_gnt != 2'b00) begin
                        if (gnt_q.size() == 0) chk("unexpected_gnt", 32'(bus.req_gnt), 32'd0);
                        else chk("gnt", 32'(bus.req_gnt), 32'(gnt_q.pop_front()));
                    end
                    if (bus.req_done != 2'b00) begin
                        done_cyc = cyc;
                        if (exp_q.size() == 0) chk("unexpected_done", 32'(bus.req_done), 32'd0);
                        else begin
                            e = exp_q.pop_front();
                            chk("done_vec", 32'(bus.req_done), 32'(e.done));
                            chk("rdata", bus.req_rdata, e.rdata);
                            chk("err", 32'(bus.req_err), 32'(e.err));
                        end
                    end
                end
            end
            begin : watchdog
                #200000;
                $display("FAIL watchdog: simulation did not finish");
                $fatal(1);
            end
        join_none

        // Reset values
        repeat (2) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("rst_psel",    32'(bus.PSEL),     32'd0);
        chk("rst_penable", 32'(bus.PENABLE),  32'd0);
        chk("rst_pwrite",  32'(bus.PWRITE),   32'd0);
        chk("rst_paddr",   32'(bus.PADDR),    32'd0);
        chk("rst_pwdata",  bus.PWDATA,        32'd0);
        chk("rst_done",    32'(bus.req_done), 32'd0);
        chk("rst_rdata",   bus.req_rdata,     32'd0);
        chk("rst_err",     32'(bus.req_err),  32'd0);
        @(posedge PCLK);
        #1;

        // Write with one wait state, phase-by-phase bus checks
        slv_wait = 1;
        t0 = cyc;
        set_req(0, 1'b1, 4'h4, 32'hDEADBEEF);
        expect_xfer(2'b01, 32'h0, 1'b0);
        step();
        chk("setup_psel",    32'(bus.PSEL),    32'd1);
        chk("setup_penable", 32'(bus.PENABLE), 32'd0);
        chk("setup_paddr",   32'(bus.PADDR),   32'h4);
        chk("setup_pwrite",  32'(bus.PWRITE),  32'd1);
        chk("setup_pwdata",  bus.PWDATA,       32'hDEADBEEF);
        step();
        chk("acc1_penable",  32'(bus.PENABLE), 32'd1);
        chk("acc1_paddr",    32'(bus.PADDR),   32'h4);
        step();
        chk("acc2_penable",  32'(bus.PENABLE), 32'd1);
        chk("acc2_pwdata",   bus.PWDATA,       32'hDEADBEEF);
        chk("acc2_pwrite",   32'(bus.PWRITE),  32'd1);
        wait_done("wr_drain", 10);
        chk("wr_latency", 32'(done_cyc - t0), 32'd4);

        // Read back
        set_req(0, 1'b0, 4'h4, 32'h0);
        expect_xfer(2'b01, 32'hDEADBEEF, 1'b0);
        wait_done("rd_drain", 10);

        // Simultaneous pairs after reset alternate req0, req1
        do_reset();
        slv_wait = 0;
        set_req(0, 1'b1, 4'h0, 32'hA1A1A1A1);
        set_req(1, 1'b1, 4'h8, 32'hB2B2B2B2);
        expect_xfer(2'b01, 32'h0, 1'b0);
        expect_xfer(2'b10, 32'h0, 1'b0);
        wait_done("pair1_drain", 20);
        set_req(0, 1'b1, 4'h0, 32'hC3C3C3C3);
        set_req(1, 1'b1, 4'h8, 32'hD4D4D4D4);
        expect_xfer(2'b01, 32'h0, 1'b0);
        expect_xfer(2'b10, 32'h0, 1'b0);
        wait_done("pair2_drain", 20);
        set_req(0, 1'b0, 4'h8, 32'h0);
        expect_xfer(2'b01, 32'hD4D4D4D4, 1'b0);
        wait_done("rd8_drain", 10);

        // Zero-wait read from req1
        t0 = cyc;
        set_req(1, 1'b0, 4'hC, 32'h0);
        expect_xfer(2'b10, 32'h12345678, 1'b0);
        wait_done("rdc_drain", 10);
        chk("zw_latency", 32'(done_cyc - t0), 32'd3);

        // Timeout: slave never ready
        slv_never = 1'b1;
        acc_cyc = 0;
        set_req(0, 1'b0, 4'h0, 32'h0);
        expect_xfer(2'b01, 32'h0, 1'b1);
        wait_done("to_drain", 40);
        chk("to_access_cycles", 32'(acc_cyc), 32'd16);
        step();
        chk("to_psel_idle", 32'(bus.PSEL), 32'd0);
        slv_never = 1'b0;

        // Stale PREADY outside ACCESS must not shorten the transfer
        slv_stale = 1'b1;
        slv_wait  = 2;
        t0 = cyc;
        set_req(1, 1'b1, 4'h2, 32'h55AA55AA);
        expect_xfer(2'b10, 32'h0, 1'b0);
        wait_done("stale_drain", 12);
        chk("stale_latency", 32'(done_cyc - t0), 32'd5);
        slv_stale = 1'b0;

        // Reset during second ACCESS cycle: bus drops, no completion
        slv_wait = 3;
        set_req(0, 1'b1, 4'h5, 32'h0BADF00D);
        gnt_q.push_back(2'b01);
        step();
        step();
        step();
        chk("pre_rst_penable", 32'(bus.PENABLE), 32'd1);
        PRESET = 1'b1;
        bus.req_valid = 2'b00;
        #1;
        chk("mid_rst_psel",    32'(bus.PSEL),    32'd0);
        chk("mid_rst_penable", 32'(bus.PENABLE), 32'd0);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        repeat (6) step();
        chk("rst_gnt_drain", 32'(gnt_q.size()), 32'd0);
        slv_wait = 0;
        set_req(1, 1'b0, 4'hC, 32'h0);
        expect_xfer(2'b10, 32'h12345678, 1'b0);
        wait_done("post_rst_drain", 10);

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
